rx78_psg: RTL and testbench

RX78_PSG -- requirements
Module: rx78_psg

---
 rtl/rx78_psg.sv | 188 ++++++++++++++++++
 tb/tb_rx78_psg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx78_psg.sv
// RX-78 sound generator: three square-wave tone channels plus one LFSR noise
// channel, 4-bit attenuation per channel, summed into a registered 10-bit sample.
module rx78_psg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [9:0] audio
);

    logic [9:0]  period [3];
    logic [9:0]  count  [3];
    logic [3:0]  atten  [4];
    logic [2:0]  flip;
    logic [2:0]  flip_next;
    logic [2:0]  nc;
    logic [2:0]  latch;
    logic [3:0]  prescale;
    logic [14:0] lfsr;
    logic [5:0]  ncount;
    logic [5:0]  nlimit;
    logic        nflip;
    logic        tick;
    logic        int_rise;
    logic        noise_rise;
    logic        nc_write;
    logic        feedback;
    logic [2:0]  sel;
    logic [9:0]  mix;

    function automatic logic [7:0] level(input logic [3:0] a);
        logic [7:0] v;
        case (a)
            4'd0:    v = 8'd255;
            4'd1:    v = 8'd203;
            4'd2:    v = 8'd161;
            4'd3:    v = 8'd128;
            4'd4:    v = 8'd102;
            4'd5:    v = 8'd81;
            4'd6:    v = 8'd64;
            4'd7:    v = 8'd51;
            4'd8:    v = 8'd40;
            4'd9:    v = 8'd32;
            4'd10:   v = 8'd26;
            4'd11:   v = 8'd20;
            4'd12:   v = 8'd16;
            4'd13:   v = 8'd13;
            4'd14:   v = 8'd10;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    assign tick     = cen && (prescale == 4'hF);
    // A latch byte addresses its own register; a data byte uses the stored pointer.
    assign sel      = din[7] ? din[6:4] : latch;
    assign nc_write = wr && (sel == 3'b110);

    // Next tone flip-flop state; periods of 0 or 1 pin the output high.
    always_comb begin
        flip_next = flip;
        for (int unsigned n = 0; n < 3; n++) begin
            if (tick && count[n] <= 10'd1) begin
                flip_next[n] = ~flip[n];
            end
            if (period[n] <= 10'd1) begin
                flip_next[n] = 1'b1;
            end
        end
    end

    // Noise clock selection and LFSR feedback.
    always_comb begin
        case (nc[1:0])
            2'd0:    nlimit = 6'd15;
            2'd1:    nlimit = 6'd31;
            default: nlimit = 6'd63;
        endcase
        int_rise   = tick && (ncount >= nlimit) && !nflip;
        noise_rise = (nc[1:0] == 2'd3) ? (!flip[2] && flip_next[2]) : int_rise;
        feedback   = nc[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];
    end

    // Channel mix from current register state.
    always_comb begin
        mix = 10'(flip[0] ? level(atten[0]) : 8'd0)
            + 10'(flip[1] ? level(atten[1]) : 8'd0)
            + 10'(flip[2] ? level(atten[2]) : 8'd0)
            + 10'(lfsr[0] ? level(atten[3]) : 8'd0);
    end

    // Divide cen by 16 to produce the tone/noise tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescale <= '0;
        end else if (cen) begin
            prescale <= prescale + 4'd1;
        end
    end

    // Tone down-counters; reload from the period held before any same-cycle write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned n = 0; n < 3; n++) begin
                count[n] <= '0;
            end
            flip <= '0;
        end else begin
            for (int unsigned n = 0; n < 3; n++) begin
                if (tick) begin
                    if (count[n] <= 10'd1) begin
                        count[n] <= period[n];
                    end else begin
                        count[n] <= count[n] - 10'd1;
                    end
                end
            end
            flip <= flip_next;
        end
    end

    // Internal noise square generator and LFSR; an NC write reload beats a shift.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ncount <= '0;
            nflip  <= 1'b0;
            lfsr   <= 15'h4000;
        end else begin
            if (tick) begin
                if (ncount >= nlimit) begin
                    ncount <= '0;
                    nflip  <= ~nflip;
                end else begin
                    ncount <= ncount + 6'd1;
                end
            end
            if (nc_write) begin
                lfsr <= 15'h4000;
            end else if (noise_rise) begin
                lfsr <= {feedback, lfsr[14:1]};
            end
        end
    end

    // Register file writes from the I/O port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned n = 0; n < 3; n++) begin
                period[n] <= '0;
            end
            for (int unsigned n = 0; n < 4; n++) begin
                atten[n] <= '1;
            end
            nc    <= '0;
            latch <= '0;
        end else if (wr) begin
            if (din[7]) begin
                latch <= din[6:4];
            end
            if (sel[0]) begin
                atten[sel[2:1]] <= din[3:0];
            end else if (sel[2:1] == 2'd3) begin
                nc <= din[2:0];
            end else begin
                for (int unsigned n = 0; n < 3; n++) begin
                    if (sel[2:1] == 2'(n)) begin
                        if (din[7]) begin
                            period[n][3:0] <= din[3:0];
                        end else begin
                            period[n][9:4] <= din[5:0];
                        end
                    end
                end
            end
        end
    end

    // Registered output sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            audio <= '0;
        end else begin
            audio <= mix;
        end
    end

endmodule

// File: tb/tb_rx78_psg.sv
// Self-checking bench for rx78_psg: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the sound generator.
module tb_rx78_psg;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cen = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [9:0] audio;

    int checks = 0;
    int errors = 0;

    rx78_psg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cen     (cen),
        .wr      (wr),
        .din     (din),
        .audio   (audio)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int vol[16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};
    int m_per[3];
    int m_cnt[3];
    int m_f[3];
    int m_att[4];
    int m_nc, m_l, m_pre, m_lfsr, m_ncnt, m_nf, m_audio;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 3; n++) begin
            m_per[n] = 0;
            m_cnt[n] = 0;
            m_f[n]   = 0;
        end
        for (int n = 0; n < 4; n++) m_att[n] = 15;
        m_nc = 0; m_l = 0; m_pre = 0; m_lfsr = 'h4000;
        m_ncnt = 0; m_nf = 0; m_audio = 0;
    endfunction

    // One clock edge of the sound generator, using the inputs present at that edge.
    function automatic void model_step();
        int next_audio, lim, ch, at, nc_old, fb;
        bit tick, irise, rise, ncw, f2_old;
        if (!reset_n) begin
            model_reset();
            return;
        end
        next_audio = (m_lfsr % 2 == 1) ? vol[m_att[3]] : 0;
        for (int n = 0; n < 3; n++) next_audio += (m_f[n] == 1) ? vol[m_att[n]] : 0;
        tick = cen && (m_pre == 15);
        if (cen) m_pre = (m_pre + 1) % 16;
        f2_old = (m_f[2] == 1);
        for (int n = 0; n < 3; n++) begin
            if (tick) begin
                if (m_cnt[n] < 2) begin
                    m_cnt[n] = m_per[n];
                    m_f[n] = 1 - m_f[n];
                end else begin
                    m_cnt[n] = m_cnt[n] - 1;
                end
            end
            if (m_per[n] < 2) m_f[n] = 1;
        end
        lim = (m_nc % 4 == 3) ? 64 : (16 << (m_nc % 4));
        irise = 0;
        if (tick) begin
            if (m_ncnt + 1 >= lim) begin
                m_ncnt = 0;
                irise = (m_nf == 0);
                m_nf = 1 - m_nf;
            end else begin
                m_ncnt = m_ncnt + 1;
            end
        end
        rise = (m_nc % 4 == 3) ? (!f2_old && m_f[2] == 1) : irise;
        nc_old = m_nc;
        ncw = 0;
        if (wr) begin
            if (din[7]) m_l = (int'(din) >> 4) & 7;
            ch = (din[7] ? ((int'(din) >> 4) & 7) : m_l) >> 1;
            at = (din[7] ? ((int'(din) >> 4) & 7) : m_l) & 1;
            if (at == 1) m_att[ch] = int'(din) & 15;
            else if (ch == 3) begin
                m_nc = int'(din) & 7;
                ncw = 1;
            end else if (din[7]) m_per[ch] = (m_per[ch] & 'h3F0) | (int'(din) & 15);
            else m_per[ch] = ((int'(din) & 63) << 4) | (m_per[ch] & 15);
        end
        if (ncw) m_lfsr = 'h4000;
        else if (rise) begin
            fb = (nc_old >= 4) ? ((m_lfsr ^ (m_lfsr >> 1)) & 1) : (m_lfsr & 1);
            m_lfsr = (m_lfsr >> 1) | (fb << 14);
        end
        m_audio = next_audio;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("audio", int'(audio), m_audio);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr  = 1'b1;
        din = d;
        step();
        wr  = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int mx, mn, gap, s, waited;
        int edges[$];
        logic [9:0] prev;
        logic [14:0] plfsr;

        model_reset();
        cen = 1'b1;
        do_reset();
        check("reset_audio", int'(audio), 0);

        // Idle after reset: silence.
        mx = 0;
        repeat (10000) begin
            step();
            if (int'(audio) > mx) mx = int'(audio);
        end
        check("idle_max", mx, 0);

        // T0=14, A0=0: square of half-period 224 clk.
        do_reset();
        wr_byte(8'h8E);
        wr_byte(8'h00);
        wr_byte(8'h90);
        prev = audio;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (audio != prev) begin
                edges.push_back(i);
                prev = audio;
            end
        end
        gap = (edges.size() >= 3) ? edges[2] - edges[1] : -1;
        check("t0_half_a", gap, 224);
        gap = (edges.size() >= 4) ? edges[3] - edges[2] : -1;
        check("t0_half_b", gap, 224);

        // T0=1 pins output high; A0=7 -> constant 51.
        do_reset();
        wr_byte(8'h81);
        wr_byte(8'h9F);
        wr_byte(8'h97);
        repeat (3) step();
        mn = 1023;
        mx = 0;
        repeat (600) begin
            step();
            if (int'(audio) > mx) mx = int'(audio);
            if (int'(audio) < mn) mn = int'(audio);
        end
        check("t0_const_min", mn, 51);
        check("t0_const_max", mx, 51);

        // All channels full volume: peak 1020 once LFSR bit0 rises.
        do_reset();
        wr_byte(8'h81);
        wr_byte(8'hA1);
        wr_byte(8'hC1);
        wr_byte(8'h90);
        wr_byte(8'hB0);
        wr_byte(8'hD0);
        wr_byte(8'hF0);
        wr_byte(8'hE4);
        mx = 0;
        repeat (9000) begin
            step();
            if (int'(audio) > mx) mx = int'(audio);
        end
        check("full_peak", mx, 1020);

        // NC write reloads the LFSR, then white-noise sequence follows.
        wr_byte(8'hE4);
        check("lfsr_reload", int'(dut.lfsr), 'h4000);
        s = 'h4000;
        for (int k = 0; k < 15; k++) begin
            plfsr = dut.lfsr;
            waited = 0;
            while (dut.lfsr == plfsr && waited < 2000) begin
                step();
                waited++;
            end
            if (waited >= 2000) begin
                check("lfsr_shift_timeout", waited, 0);
                break;
            end
            s = (s >> 1) | (((s ^ (s >> 1)) & 1) << 14);
            check("lfsr_bit0", int'(dut.lfsr[0]), s & 1);
            check("lfsr_state", int'(dut.lfsr), s);
        end

        // Reset between latch and data byte: data byte lands in T0[9:4].
        do_reset();
        wr_byte(8'h8E);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wr_byte(8'h05);
        step();
        step();
        check("abort_t0", int'(dut.period[0]), 'h050);
        check("abort_a0", int'(dut.atten[0]), 15);
        check("abort_audio", int'(audio), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            reset_n = ($urandom_range(0, 999) != 0);
            cen     = ($urandom_range(0, 3) != 0);
            wr      = ($urandom_range(0, 4) == 0);
            din     = 8'($urandom);
            step();
        end
        reset_n = 1'b1;
        wr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
